// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the branch redirect controller.
// Holds the XLEN width, control-flow opcodes, the redirect FSM state type
// and the width of the squash down-counter.
package rv32_pkg;

    localparam int unsigned XLEN  = 32;
    localparam int unsigned CNT_W = 3;

    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_REDIRECT = 2'd1,
        ST_SQUASH   = 2'd2
    } brc_state_e;

endpackage

// File: rtl/perf_counter.sv
// Free-running performance counter with synchronous reset and wrap-around.
// Ports:
//   clk     - clock
//   rst     - synchronous active-high reset, clears the count
//   i_inc   - increment enable for this cycle
//   o_count - current count (registered)
module perf_counter
    import rv32_pkg::*;
#(
    parameter int unsigned WIDTH = XLEN
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_inc,
    output logic [WIDTH-1:0] o_count
);

    logic [WIDTH-1:0] r_count;

    // Natural modulo-2^WIDTH wrap from all-ones back to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_inc) begin
            r_count <= r_count + WIDTH'(1);
        end
    end

    assign o_count = r_count;

endmodule

// File: rtl/branch_redirect_ctrl.sv
// EX-stage branch/jump redirect controller.
// Samples control-flow events in EX, computes the target, redirects fetch
// and squashes IF/ID and ID/EX for FLUSH_CYCLES stall-free cycles.
// Ports:
//   clk, rst                    - clock, synchronous active-high reset
//   ex_valid/ex_is_branch/ex_taken/ex_is_jump - EX instruction description
//   ex_pc, ex_deviation         - branch base PC and signed byte offset
//   ex_jump_target              - JAL/JALR target before bit-0 clear
//   stall_in                    - pipeline stall, EX does not advance
//   redirect_valid, redirect_pc - fetch redirect request and address
//   flush_ifid, flush_idex      - squash pipeline registers
//   misalign_err                - one-cycle pulse for a misaligned target
//   branch_count, taken_count   - performance counters
module branch_redirect_ctrl
    import rv32_pkg::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ex_valid,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic            ex_is_jump,
    input  logic [XLEN-1:0] ex_pc,
    input  logic [XLEN-1:0] ex_deviation,
    input  logic [XLEN-1:0] ex_jump_target,
    input  logic            stall_in,
    output logic            redirect_valid,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_ifid,
    output logic            flush_idex,
    output logic            misalign_err,
    output logic [XLEN-1:0] branch_count,
    output logic [XLEN-1:0] taken_count
);

    // Squash cycles that follow the single REDIRECT cycle, minus one.
    localparam logic [CNT_W-1:0] CNT_LOAD =
        (FLUSH_CYCLES > 1) ? CNT_W'(FLUSH_CYCLES - 2) : CNT_W'(0);
    localparam bit SINGLE_FLUSH = (FLUSH_CYCLES <= 1);

    brc_state_e      r_state;
    brc_state_e      w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic            r_redirect_valid;
    logic            r_flush;
    logic            r_misalign;
    logic [XLEN-1:0] r_redirect_pc;

    logic            w_redirect_valid_nxt;
    logic            w_flush_nxt;
    logic            w_misalign_nxt;
    logic [XLEN-1:0] w_redirect_pc_nxt;

    logic            w_sample;
    logic            w_is_jump;
    logic            w_is_branch;
    logic            w_taken_inc;
    logic            w_ctl;
    logic [XLEN-1:0] w_target;

    // Event qualification: only live, advancing EX instructions while in RUN.
    assign w_sample    = (r_state == ST_RUN) && ex_valid && !stall_in;
    assign w_is_jump   = w_sample && ex_is_jump;
    assign w_is_branch = w_sample && ex_is_branch && !ex_is_jump;
    assign w_taken_inc = w_is_branch && ex_taken;
    assign w_ctl       = w_is_jump || w_taken_inc;

    // Jump target has bit 0 cleared; branch target wraps modulo 2^XLEN.
    assign w_target = ex_is_jump ? (ex_jump_target & ~XLEN'(1))
                                 : (ex_pc + ex_deviation);

    // Next-state and next-output logic.
    always_comb begin
        w_state_nxt       = r_state;
        w_cnt_nxt         = r_cnt;
        w_redirect_pc_nxt = r_redirect_pc;
        w_misalign_nxt    = 1'b0;

        case (r_state)
            ST_RUN: begin
                if (w_ctl) begin
                    w_redirect_pc_nxt = w_target;
                    if (w_target[1]) begin
                        w_misalign_nxt = 1'b1;
                    end else begin
                        w_state_nxt = ST_REDIRECT;
                    end
                end
            end
            ST_REDIRECT: begin
                if (!stall_in) begin
                    if (SINGLE_FLUSH) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_state_nxt = ST_SQUASH;
                        w_cnt_nxt   = CNT_LOAD;
                    end
                end
            end
            ST_SQUASH: begin
                if (!stall_in) begin
                    if (r_cnt == '0) begin
                        w_state_nxt = ST_RUN;
                    end else begin
                        w_cnt_nxt = r_cnt - CNT_W'(1);
                    end
                end
            end
            default: begin
                w_state_nxt = ST_RUN;
                w_cnt_nxt   = '0;
            end
        endcase

        // Outputs are registered images of the state being entered.
        w_redirect_valid_nxt = (w_state_nxt == ST_REDIRECT);
        w_flush_nxt          = (w_state_nxt != ST_RUN);
    end

    // State and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= ST_RUN;
            r_cnt            <= '0;
            r_redirect_valid <= 1'b0;
            r_flush          <= 1'b0;
            r_misalign       <= 1'b0;
            r_redirect_pc    <= '0;
        end else begin
            r_state          <= w_state_nxt;
            r_cnt            <= w_cnt_nxt;
            r_redirect_valid <= w_redirect_valid_nxt;
            r_flush          <= w_flush_nxt;
            r_misalign       <= w_misalign_nxt;
            r_redirect_pc    <= w_redirect_pc_nxt;
        end
    end

    perf_counter #(.WIDTH(XLEN)) u_branch_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_is_branch),
        .o_count (branch_count)
    );

    perf_counter #(.WIDTH(XLEN)) u_taken_cnt (
        .clk     (clk),
        .rst     (rst),
        .i_inc   (w_taken_inc),
        .o_count (taken_count)
    );

    assign redirect_valid = r_redirect_valid;
    assign redirect_pc    = r_redirect_pc;
    assign flush_ifid     = r_flush;
    assign flush_idex     = r_flush;
    assign misalign_err   = r_misalign;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed scenarios with
// literal expectations plus randomized traffic against a behavioural model.
module tb_branch_redirect_ctrl;

    localparam int unsigned FC = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_valid, ex_is_branch, ex_taken, ex_is_jump, stall_in;
    logic [31:0] ex_pc, ex_deviation, ex_jump_target;
    logic        redirect_valid, flush_ifid, flush_idex, misalign_err;
    logic [31:0] redirect_pc, branch_count, taken_count;

    int n_cmp = 0;
    int n_err = 0;
    bit check_en = 1'b0;
    bit preload_req = 1'b0;

    // Behavioural model: remaining stall-free flush cycles and whether the
    // first (redirect) one is still pending.
    int          m_fl = 0;
    bit          m_first = 1'b0;
    bit          m_mis = 1'b0;
    logic [31:0] m_rpc = '0, m_bc = '0, m_tc = '0;

    always #5 clk = ~clk;

    branch_redirect_ctrl #(.FLUSH_CYCLES(FC)) dut (
        .clk            (clk),
        .rst            (rst),
        .ex_valid       (ex_valid),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_is_jump     (ex_is_jump),
        .ex_pc          (ex_pc),
        .ex_deviation   (ex_deviation),
        .ex_jump_target (ex_jump_target),
        .stall_in       (stall_in),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .flush_ifid     (flush_ifid),
        .flush_idex     (flush_idex),
        .misalign_err   (misalign_err),
        .branch_count   (branch_count),
        .taken_count    (taken_count)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin : model
        bit jmp, br;
        logic [31:0] tgt;
        if (rst) begin
            m_fl = 0; m_first = 1'b0; m_mis = 1'b0;
            m_rpc = '0; m_bc = '0; m_tc = '0;
        end else begin
            if (preload_req) m_tc = 32'hFFFF_FFFF;
            m_mis = 1'b0;
            if (m_fl > 0) begin
                if (!stall_in) begin
                    m_fl = m_fl - 1;
                    m_first = 1'b0;
                end
            end else if (ex_valid && !stall_in) begin
                jmp = ex_is_jump;
                br  = ex_is_branch && !ex_is_jump;
                if (br) m_bc = m_bc + 32'd1;
                if (br && ex_taken) m_tc = m_tc + 32'd1;
                if (jmp || (br && ex_taken)) begin
                    tgt = jmp ? (ex_jump_target & 32'hFFFF_FFFE) : (ex_pc + ex_deviation);
                    m_rpc = tgt;
                    if (tgt[1]) m_mis = 1'b1;
                    else begin
                        m_fl = int'(FC);
                        m_first = 1'b1;
                    end
                end
            end
        end
    end

    always @(negedge clk) begin : compare
        if (check_en) begin
            chk("redirect_valid", 32'(redirect_valid), 32'(m_fl > 0 && m_first));
            chk("redirect_pc",    redirect_pc, m_rpc);
            chk("flush_ifid",     32'(flush_ifid), 32'(m_fl > 0));
            chk("flush_idex",     32'(flush_idex), 32'(m_fl > 0));
            chk("misalign_err",   32'(misalign_err), 32'(m_mis));
            chk("branch_count",   branch_count, m_bc);
            chk("taken_count",    taken_count, m_tc);
        end
    end

    task automatic set_in(input bit v, input bit b, input bit t, input bit j,
                          input logic [31:0] pc, input logic [31:0] dev,
                          input logic [31:0] jt, input bit st, input bit r);
        ex_valid = v; ex_is_branch = b; ex_taken = t; ex_is_jump = j;
        ex_pc = pc; ex_deviation = dev; ex_jump_target = jt;
        stall_in = st; rst = r;
    endtask

    task automatic step(input bit v, input bit b, input bit t, input bit j,
                        input logic [31:0] pc, input logic [31:0] dev,
                        input logic [31:0] jt, input bit st, input bit r);
        set_in(v, b, t, j, pc, dev, jt, st, r);
        @(negedge clk);
    endtask

    task automatic idle(input bit st);
        step(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, st, 1'b0);
    endtask

    initial begin : stim
        int rv_cycles;
        set_in(1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        check_en = 1'b1;
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'h8, 32'h0, 1'b0, 1'b1);
        chk("reset_rv",    32'(redirect_valid), 32'd0);
        chk("reset_flush", 32'(flush_ifid | flush_idex), 32'd0);
        chk("reset_bc",    branch_count, 32'd0);

        // Taken branch with negative offset.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h100, 32'hFFFF_FFF0, 32'h0, 1'b0, 1'b0);
        chk("br_rv",  32'(redirect_valid), 32'd1);
        chk("br_pc",  redirect_pc, 32'h0F0);
        chk("br_bc",  branch_count, 32'd1);
        chk("br_tc",  taken_count, 32'd1);
        idle(1'b0);
        chk("br_sq_flush", 32'(flush_ifid), 32'd1);
        chk("br_sq_rv",    32'(redirect_valid), 32'd0);
        idle(1'b0);
        chk("br_end_flush", 32'(flush_idex), 32'd0);

        // Jump wins over branch; target 0x2002 is misaligned.
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h0, 32'h0, 32'h2003, 1'b0, 1'b0);
        chk("jmp_pc",  redirect_pc, 32'h2002);
        chk("jmp_mis", 32'(misalign_err), 32'd1);
        chk("jmp_rv",  32'(redirect_valid), 32'd0);
        chk("jmp_bc",  branch_count, 32'd1);
        idle(1'b0);
        chk("jmp_mis_pulse", 32'(misalign_err), 32'd0);

        // Stall held in REDIRECT.
        rv_cycles = 0;
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h200, 32'h40, 32'h0, 1'b0, 1'b0);
        if (redirect_valid === 1'b1 && redirect_pc === 32'h240) rv_cycles++;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'b1, 1'b1, 1'b0, 32'h900, 32'h4, 32'h0, 1'b1, 1'b0);
            if (redirect_valid === 1'b1 && redirect_pc === 32'h240) rv_cycles++;
        end
        chk("stall_rv_cycles", 32'(rv_cycles), 32'd4);
        idle(1'b0);
        chk("stall_sq_rv",    32'(redirect_valid), 32'd0);
        chk("stall_sq_flush", 32'(flush_ifid), 32'd1);
        idle(1'b0);
        chk("stall_run_flush", 32'(flush_ifid), 32'd0);

        // Back-to-back taken branches: second is wrong-path.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h300, 32'h8, 32'h0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h400, 32'h8, 32'h0, 1'b0, 1'b0);
        chk("b2b_pc", redirect_pc, 32'h308);
        chk("b2b_bc", branch_count, 32'd3);
        chk("b2b_tc", taken_count, 32'd3);
        idle(1'b0);

        // Reset in the middle of SQUASH.
        step(1'b1, 1'b1, 1'b1, 1'b0, 32'h500, 32'h4, 32'h0, 1'b0, 1'b0);
        idle(1'b0);
        chk("mid_sq_flush", 32'(flush_ifid), 32'd1);
        step(1'b1, 1'b1, 1'b1, 1'b1, 32'h700, 32'h8, 32'h800, 1'b0, 1'b1);
        chk("rst_sq_flush", 32'(flush_ifid | flush_idex | redirect_valid | misalign_err), 32'd0);
        chk("rst_sq_pc",    redirect_pc, 32'd0);
        chk("rst_sq_bc",    branch_count, 32'd0);
        chk("rst_sq_tc",    taken_count, 32'd0);

        // taken_count wrap via preload, then a not-taken branch.
        #2;
        force dut.u_taken_cnt.r_count = 32'hFFFF_FFFF;
        preload_req = 1'b1;
        set_in(1'b1, 1'b1, 1'b1, 1'b0, 32'h600, 32'h10, 32'h0, 1'b0, 1'b0);
        #1;
        release dut.u_taken_cnt.r_count;
        @(negedge clk);
        preload_req = 1'b0;
        chk("wrap_tc", taken_count, 32'd0);
        chk("wrap_bc", branch_count, 32'd1);
        idle(1'b0);
        idle(1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0, 32'h640, 32'h20, 32'h0, 1'b0, 1'b0);
        chk("nt_flush", 32'(flush_ifid | flush_idex | redirect_valid), 32'd0);
        chk("nt_bc",    branch_count, 32'd2);
        chk("nt_tc",    taken_count, 32'd0);

        // Randomized traffic checked every cycle by the compare process.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] pc, dev, jt;
            pc  = $urandom & 32'hFFFF_FFFC;
            dev = ($urandom_range(0, 7) == 0) ? ($urandom & 32'hFFFF_FFFE)
                                              : (32'($urandom_range(0, 255)) << 1);
            jt  = $urandom;
            step($urandom_range(0, 9) < 7, $urandom_range(0, 1) == 1,
                 $urandom_range(0, 1) == 1, $urandom_range(0, 3) == 0,
                 pc, dev, jt, $urandom_range(0, 4) == 0,
                 $urandom_range(0, 99) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
